// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped, read-only cache.
// Address layout is tag(3) | index(10) | offset(2), one 4-word line per index.
package cache_pkg;

  localparam int TAG_W          = 3;
  localparam int OFF_W          = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int INDEX_W        = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL,
    RESP
  } cache_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [OFF_W-1:0]   offset;
  } cache_addr_t;

  // Memory fetches whole lines, so the request always starts at word 0 of the block.
  function automatic logic [TAG_W+INDEX_W+OFF_W-1:0] block_addr(input cache_addr_t a);
    return {a.tag, a.index, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag store for the direct-mapped cache: one combinational lookup port,
// one synchronous write port; only the valid bits are cleared by reset.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             hit_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags need no reset: a stale tag is harmless while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/cache_controller.sv
// Read-only direct-mapped cache controller: tag lookup, 4-beat line refill, CPU response.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10,
  parameter int STAT_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int LINES = 2 ** IDX_W;
  localparam int DEPTH = LINES * WORDS_PER_LINE;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  cache_state_t      state_q, state_d;
  cache_addr_t       addr_q, addr_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] crit_q, crit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [DATA_W-1:0] data_q [DEPTH];

  logic                   lookup_hit;
  logic                   tag_wr_en;
  logic                   data_wr_en;
  logic [IDX_W+OFF_W-1:0] rd_ptr;
  logic [IDX_W+OFF_W-1:0] wr_ptr;

  assign rd_ptr = {addr_q.index, addr_q.offset};
  assign wr_ptr = {addr_q.index, beat_q};

  cache_tag_store #(
    .IDX_W(IDX_W)
  ) u_tag_store (
    .clk     (clk),
    .rst     (rst),
    .rd_idx_i(addr_q.index),
    .rd_tag_i(addr_q.tag),
    .hit_o   (lookup_hit),
    .wr_en_i (tag_wr_en),
    .wr_idx_i(addr_q.index),
    .wr_tag_i(addr_q.tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      crit_q     <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      crit_q     <= crit_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_wr_en) begin
      data_q[wr_ptr] <= mem_rdata;
    end
  end

  // cpu_rdata is combinational on the ready cycle and falls back to the last returned word.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    crit_d     = crit_q;
    mem_addr_d = mem_addr_q;
    cpu_ready  = 1'b0;
    cpu_hit    = 1'b0;
    cpu_rdata  = rdata_q;
    tag_wr_en  = 1'b0;
    data_wr_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          cpu_ready = 1'b1;
          cpu_hit   = 1'b1;
          cpu_rdata = data_q[rd_ptr];
          state_d   = IDLE;
        end else begin
          mem_addr_d = block_addr(addr_q);
          beat_d     = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_valid) begin
          data_wr_en = 1'b1;
          beat_d     = beat_q + 2'd1;
          if (beat_q == addr_q.offset) begin
            crit_d = mem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            tag_wr_en = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = crit_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata_d  = cpu_rdata;
  assign mem_req  = (state_q == FILL);
  assign mem_addr = mem_addr_q;

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (lookup_hit) begin
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller: cold miss, hit, conflict,
// stalled refill and reset during refill, with a scripted main-memory responder.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [14:0] hit_count;
  logic [14:0] miss_count;

  int checks = 0;
  int errors = 0;

  cache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_hit   (cpu_hit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One complete CPU read; on a miss the bench plays main memory, optionally
  // stalling gapLen cycles before beat gapBeat.
  task automatic applyStimulus(input string tag, input logic [14:0] addr, input logic expHit,
                               input logic [31:0] expData, input logic [14:0] expMemAddr,
                               input logic [3:0][31:0] words, input int gapBeat, input int gapLen);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    @(posedge clk); #1;
    if (expHit) begin
      checkOutput({tag, "_ready"}, 32'(cpu_ready), 32'h1);
      checkOutput({tag, "_hit"}, 32'(cpu_hit), 32'h1);
      checkOutput({tag, "_rdata"}, cpu_rdata, expData);
      checkOutput({tag, "_memreq"}, 32'(mem_req), 32'h0);
    end else begin
      checkOutput({tag, "_lookup_ready"}, 32'(cpu_ready), 32'h0);
      @(posedge clk); #1;
      checkOutput({tag, "_memreq"}, 32'(mem_req), 32'h1);
      checkOutput({tag, "_memaddr"}, 32'(mem_addr), 32'(expMemAddr));
      for (int b = 0; b < 4; b++) begin
        if (b == gapBeat) begin
          for (int g = 0; g < gapLen; g++) begin
            mem_valid = 1'b0;
            @(posedge clk); #1;
            checkOutput({tag, "_gap_memreq"}, 32'(mem_req), 32'h1);
            checkOutput({tag, "_gap_ready"}, 32'(cpu_ready), 32'h0);
          end
        end
        mem_valid = 1'b1;
        mem_rdata = words[b];
        @(posedge clk); #1;
        mem_valid = 1'b0;
      end
      checkOutput({tag, "_ready"}, 32'(cpu_ready), 32'h1);
      checkOutput({tag, "_hit"}, 32'(cpu_hit), 32'h0);
      checkOutput({tag, "_rdata"}, cpu_rdata, expData);
      checkOutput({tag, "_memreq_off"}, 32'(mem_req), 32'h0);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, "_ready_pulse"}, 32'(cpu_ready), 32'h0);
    checkOutput({tag, "_rdata_hold"}, cpu_rdata, expData);
  endtask

  logic [3:0][31:0] wordsA, wordsB, wordsD, wordsE, wordsF;
  logic [14:0] expHits, expMisses;

  initial begin
    wordsA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    wordsB = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    wordsD = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    wordsE = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    wordsF = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
`ifdef CACHE_STATS_EN
    expHits   = 15'd1;
    expMisses = 15'd2;
`else
    expHits   = 15'd0;
    expMisses = 15'd0;
`endif

    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(cpu_ready), 32'h0);
    checkOutput("rst_hit", 32'(cpu_hit), 32'h0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_memreq", 32'(mem_req), 32'h0);
    checkOutput("rst_memaddr", 32'(mem_addr), 32'h0);
    checkOutput("rst_hitcnt", 32'(hit_count), 32'h0);
    checkOutput("rst_misscnt", 32'(miss_count), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("cold_miss", 15'h0005, 1'b0, 32'hA1, 15'h0004, wordsA, 4, 0);

    // Stray refill beats while idle must not disturb anything.
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 1'b0;
    checkOutput("stray_memreq", 32'(mem_req), 32'h0);

    applyStimulus("hit_after_fill", 15'h0007, 1'b1, 32'hA3, 15'h0000, wordsA, 4, 0);
    applyStimulus("conflict", 15'h1004, 1'b0, 32'hB0, 15'h1004, wordsB, 4, 0);
    checkOutput("stats_hits", 32'(hit_count), 32'(expHits));
    checkOutput("stats_misses", 32'(miss_count), 32'(expMisses));
    applyStimulus("conflict_back", 15'h0004, 1'b0, 32'hA0, 15'h0004, wordsA, 4, 0);

    applyStimulus("stalled", 15'h0106, 1'b0, 32'hE2, 15'h0104, wordsE, 2, 3);
    applyStimulus("stalled_hit", 15'h0105, 1'b1, 32'hE1, 15'h0000, wordsE, 4, 0);
    applyStimulus("other_line", 15'h0006, 1'b1, 32'hA2, 15'h0000, wordsA, 4, 0);

    // Abort a refill of 0x0208 after two beats.
    cpu_addr = 15'h0208;
    cpu_req  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort_memreq_pre", 32'(mem_req), 32'h1);
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1;
      mem_rdata = wordsF[b];
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    cpu_req   = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput("abort_memreq", 32'(mem_req), 32'h0);
    checkOutput("abort_ready", 32'(cpu_ready), 32'h0);
    @(posedge clk); #1;
    checkOutput("abort_ready_held", 32'(cpu_ready), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_ready_after", 32'(cpu_ready), 32'h0);
    checkOutput("abort_hitcnt", 32'(hit_count), 32'h0);
    checkOutput("abort_misscnt", 32'(miss_count), 32'h0);

    applyStimulus("reread", 15'h0208, 1'b0, 32'hD0, 15'h0208, wordsD, 4, 0);
    applyStimulus("post_reset_miss", 15'h0105, 1'b0, 32'hF1, 15'h0104, wordsF, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
